// File: rtl/pid_pkg.sv
// pid_pkg: shared widths, sequencer state encoding and saturation helpers
// for the two-axis incremental-PID scheduler.
//   E_W : error / coordinate width (signed)
//   G_W : gain width (unsigned)
//   U_W : accumulated servo command width (signed)
package pid_pkg;

   localparam int E_W = 10;
   localparam int G_W = 4;
   localparam int U_W = 15;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_X = 3'd1,
      ST_ACC_X  = 3'd2,
      ST_LOAD_Y = 3'd3,
      ST_ACC_Y  = 3'd4,
      ST_DONE   = 3'd5
   } pid_state_t;

   // 11-bit signed -> 10-bit signed. Overflow shows up as the two top bits
   // disagreeing; the sign bit tells which rail to clamp to.
   function automatic logic signed [E_W-1:0] sat_err(input logic signed [E_W:0] v);
      logic signed [E_W-1:0] r;
      if (v[E_W] != v[E_W-1])
         r = v[E_W] ? {1'b1, {(E_W-1){1'b0}}} : {1'b0, {(E_W-1){1'b1}}};
      else
         r = v[E_W-1:0];
      return r;
   endfunction

   // 16-bit signed -> 15-bit signed, same overflow rule as sat_err.
   function automatic logic signed [U_W-1:0] sat_u(input logic signed [U_W:0] v);
      logic signed [U_W-1:0] r;
      if (v[U_W] != v[U_W-1])
         r = v[U_W] ? {1'b1, {(U_W-1){1'b0}}} : {1'b0, {(U_W-1){1'b1}}};
      else
         r = v[U_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/pid_sample_tick.sv
// pid_sample_tick: control-rate divider. Counts 0..SAMPLE_DIV-1 and raises
// tick for the single cycle spent at SAMPLE_DIV-1, then wraps.
//   clk   : system clock
//   rst_n : synchronous active-low reset (counter -> 0)
//   tick  : one-cycle sample strobe
module pid_sample_tick #(
   parameter int SAMPLE_DIV = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CNT_W = $clog2(SAMPLE_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

   logic [CNT_W-1:0] count_reg;

   assign tick = (count_reg == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n)
         count_reg <= '0;
      else if (tick)
         count_reg <= '0;
      else
         count_reg <= count_reg + CNT_W'(1);
   end

endmodule

// File: rtl/pid_axis_sched.sv
// pid_axis_sched: shares one external combinational incremental-PID unit
// between the pan (X) and tilt (Y) gimbal axes.
//   clk, rst_n              : clock, synchronous active-low reset
//   coord_valid, x/y_pos    : centroid from the ball finder (latched on pulse)
//   target_x/y              : setpoints
//   kp/ki/kd_x, kp/ki/kd_y  : per-axis gains, read only while that axis accumulates
//   inc_ek0..2, inc_kp..kd  : operands to the increment unit (0 when unused)
//   inc_d_uk                : increment result, same cycle
//   pan_u, tilt_u, u_valid  : saturated commands and their update strobe
//   busy, overrun           : sequencer active; sticky tick-while-busy flag
module pid_axis_sched
   import pid_pkg::*;
#(
   parameter int SAMPLE_DIV = 1_000_000,
   parameter int U_MAX      = 16383,
   parameter int U_MIN      = -16384
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  coord_valid,
   input  logic signed [E_W-1:0] x_pos,
   input  logic signed [E_W-1:0] y_pos,
   input  logic signed [E_W-1:0] target_x,
   input  logic signed [E_W-1:0] target_y,
   input  logic [G_W-1:0]        kp_x,
   input  logic [G_W-1:0]        ki_x,
   input  logic [G_W-1:0]        kd_x,
   input  logic [G_W-1:0]        kp_y,
   input  logic [G_W-1:0]        ki_y,
   input  logic [G_W-1:0]        kd_y,
   output logic signed [E_W-1:0] inc_ek0,
   output logic signed [E_W-1:0] inc_ek1,
   output logic signed [E_W-1:0] inc_ek2,
   output logic [G_W-1:0]        inc_kp,
   output logic [G_W-1:0]        inc_ki,
   output logic [G_W-1:0]        inc_kd,
   input  logic signed [U_W-1:0] inc_d_uk,
   output logic signed [U_W-1:0] pan_u,
   output logic signed [U_W-1:0] tilt_u,
   output logic                  u_valid,
   output logic                  busy,
   output logic                  overrun
);

   pid_state_t state_reg, state_next;
   logic       tick;
   logic       start;
   logic       fresh_reg, u_valid_reg, overrun_reg;
   logic [1:0] load_en, acc_en;   // index 0 = X, 1 = Y

   logic signed [E_W-1:0] pos [2];
   logic signed [E_W-1:0] tgt [2];

   assign pos[0] = x_pos;
   assign pos[1] = y_pos;
   assign tgt[0] = target_x;
   assign tgt[1] = target_y;

   pid_sample_tick #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // A coordinate arriving on the tick cycle counts as fresh for this sample.
   assign start = (state_reg == ST_IDLE) && tick && (fresh_reg || coord_valid);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         fresh_reg   <= 1'b0;
         u_valid_reg <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         // start consumes any coordinate, including one arriving this cycle
         if (start)
            fresh_reg <= 1'b0;
         else if (coord_valid)
            fresh_reg <= 1'b1;
         // registered so the strobe lines up with the DONE cycle
         u_valid_reg <= (state_reg == ST_ACC_Y);
         if (tick && (state_reg != ST_IDLE))
            overrun_reg <= 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      load_en    = 2'b00;
      acc_en     = 2'b00;
      case (state_reg)
         ST_IDLE:   if (start) state_next = ST_LOAD_X;
         ST_LOAD_X: begin load_en[0] = 1'b1; state_next = ST_ACC_X;  end
         ST_ACC_X:  begin acc_en[0]  = 1'b1; state_next = ST_LOAD_Y; end
         ST_LOAD_Y: begin load_en[1] = 1'b1; state_next = ST_ACC_Y;  end
         ST_ACC_Y:  begin acc_en[1]  = 1'b1; state_next = ST_DONE;   end
         ST_DONE:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Per-axis datapath: shadow/snapshot, error history, accumulated command.
   for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      logic signed [E_W-1:0] shadow_reg, snap_reg, ek0_reg, ek1_reg, ek2_reg;
      logic signed [U_W-1:0] u_reg;
      logic signed [E_W:0]   err_diff;
      logic signed [U_W:0]   u_sum;
      logic signed [U_W-1:0] u_next;

      assign err_diff = {tgt[gi][E_W-1], tgt[gi]} - {snap_reg[E_W-1], snap_reg};
      assign u_sum    = {u_reg[U_W-1], u_reg} + {inc_d_uk[U_W-1], inc_d_uk};

      // Width saturation first, then the (possibly narrower) configured rails.
      always_comb begin
         u_next = sat_u(u_sum);
         if (u_next > U_MAX)
            u_next = U_W'(U_MAX);
         else if (u_next < U_MIN)
            u_next = U_W'(U_MIN);
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            shadow_reg <= '0;
            snap_reg   <= '0;
            ek0_reg    <= '0;
            ek1_reg    <= '0;
            ek2_reg    <= '0;
            u_reg      <= '0;
         end else begin
            if (coord_valid)
               shadow_reg <= pos[gi];
            if (start)
               snap_reg <= coord_valid ? pos[gi] : shadow_reg;
            if (load_en[gi])
               ek0_reg <= sat_err(err_diff);
            if (acc_en[gi]) begin
               u_reg   <= u_next;
               ek2_reg <= ek1_reg;
               ek1_reg <= ek0_reg;
            end
         end
      end
   end

   // Increment-unit operand mux; idle operands are held at zero.
   always_comb begin
      inc_ek0 = '0;
      inc_ek1 = '0;
      inc_ek2 = '0;
      inc_kp  = '0;
      inc_ki  = '0;
      inc_kd  = '0;
      if (state_reg == ST_ACC_X) begin
         inc_ek0 = g_axis[0].ek0_reg;
         inc_ek1 = g_axis[0].ek1_reg;
         inc_ek2 = g_axis[0].ek2_reg;
         inc_kp  = kp_x;
         inc_ki  = ki_x;
         inc_kd  = kd_x;
      end else if (state_reg == ST_ACC_Y) begin
         inc_ek0 = g_axis[1].ek0_reg;
         inc_ek1 = g_axis[1].ek1_reg;
         inc_ek2 = g_axis[1].ek2_reg;
         inc_kp  = kp_y;
         inc_ki  = ki_y;
         inc_kd  = kd_y;
      end
   end

   assign pan_u   = g_axis[0].u_reg;
   assign tilt_u  = g_axis[1].u_reg;
   assign u_valid = u_valid_reg;
   assign busy    = (state_reg != ST_IDLE);
   assign overrun = overrun_reg;

endmodule

// File: tb/tb_pid_axis_sched.sv
// tb_pid_axis_sched: directed table plus randomized samples for
// pid_axis_sched, with an incremental-PID increment unit and a per-sample
// reference model of both axes.
module tb_pid_axis_sched;

   localparam int SD = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic coord_valid = 1'b0;
   logic signed [9:0] x_pos = '0, y_pos = '0, target_x = '0, target_y = '0;
   logic [3:0] kp_x = '0, ki_x = '0, kd_x = '0, kp_y = '0, ki_y = '0, kd_y = '0;
   logic signed [9:0] inc_ek0, inc_ek1, inc_ek2;
   logic [3:0] inc_kp, inc_ki, inc_kd;
   logic signed [14:0] inc_d_uk;
   logic signed [14:0] pan_u, tilt_u;
   logic u_valid, busy, overrun;

   logic frc = 1'b0;
   logic signed [14:0] fval = '0;

   always #5 clk = ~clk;

   pid_axis_sched #(.SAMPLE_DIV(SD)) dut (
      .clk(clk), .rst_n(rst_n), .coord_valid(coord_valid),
      .x_pos(x_pos), .y_pos(y_pos), .target_x(target_x), .target_y(target_y),
      .kp_x(kp_x), .ki_x(ki_x), .kd_x(kd_x), .kp_y(kp_y), .ki_y(ki_y), .kd_y(kd_y),
      .inc_ek0(inc_ek0), .inc_ek1(inc_ek1), .inc_ek2(inc_ek2),
      .inc_kp(inc_kp), .inc_ki(inc_ki), .inc_kd(inc_kd), .inc_d_uk(inc_d_uk),
      .pan_u(pan_u), .tilt_u(tilt_u), .u_valid(u_valid), .busy(busy), .overrun(overrun)
   );

   function automatic int clamp(input int v, input int lo, input int hi);
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   // Increment unit: du = kp*(e0-e1) + ki*e0 + kd*(e0-2e1+e2), saturated to 15 bits.
   function automatic int unit_du(input int e0, input int e1, input int e2,
                                  input int kp, input int ki, input int kd);
      return clamp(kp * (e0 - e1) + ki * e0 + kd * (e0 - 2 * e1 + e2), -16384, 16383);
   endfunction

   always_comb begin
      inc_d_uk = frc ? fval
                     : 15'(unit_du(inc_ek0, inc_ek1, inc_ek2, inc_kp, inc_ki, inc_kd));
   end

   typedef struct {
      int tx, x, ty, y;
      int kp_x, ki_x, kd_x, kp_y, ki_y, kd_y;
      bit give, coinc, frc;
      int fval;
      bit has_exp;
      int exp_pan, exp_tilt;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int ph = 0;   // predicted sample-counter value for the current cycle

   // reference model state (index 0 = X, 1 = Y)
   int  m_u [2], m_e1 [2], m_e2 [2], m_sh [2];
   bit  m_fresh;
   int  x0 [2], x1 [2], x2 [2], xkp [2], xki [2], xkd [2];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      ph = (ph + 1) % SD;
   endtask

   task automatic model_reset();
      for (int a = 0; a < 2; a++) begin
         m_u[a] = 0; m_e1[a] = 0; m_e2[a] = 0; m_sh[a] = 0;
      end
      m_fresh = 1'b0;
   endtask

   // One control sample as the behaviour describes it, evaluated at the tick.
   task automatic model_tick(input vec_t v, output bit upd);
      int tg, e, d;
      upd = m_fresh;
      if (!upd) return;
      m_fresh = 1'b0;
      for (int a = 0; a < 2; a++) begin
         tg = (a == 0) ? v.tx : v.ty;
         xkp[a] = (a == 0) ? v.kp_x : v.kp_y;
         xki[a] = (a == 0) ? v.ki_x : v.ki_y;
         xkd[a] = (a == 0) ? v.kd_x : v.kd_y;
         e = clamp(tg - m_sh[a], -512, 511);
         x0[a] = e; x1[a] = m_e1[a]; x2[a] = m_e2[a];
         d = v.frc ? v.fval : unit_du(e, m_e1[a], m_e2[a], xkp[a], xki[a], xkd[a]);
         m_u[a] = clamp(m_u[a] + d, -16384, 16383);
         m_e2[a] = m_e1[a];
         m_e1[a] = e;
      end
   endtask

   task automatic drive_coord(input vec_t v);
      x_pos = 10'(v.x); y_pos = 10'(v.y); coord_valid = 1'b1;
      m_sh[0] = v.x; m_sh[1] = v.y; m_fresh = 1'b1;
   endtask

   task automatic apply_cfg(input vec_t v);
      target_x = 10'(v.tx); target_y = 10'(v.ty);
      kp_x = 4'(v.kp_x); ki_x = 4'(v.ki_x); kd_x = 4'(v.kd_x);
      kp_y = 4'(v.kp_y); ki_y = 4'(v.ki_y); kd_y = 4'(v.kd_y);
      frc = v.frc; fval = 15'(v.fval);
   endtask

   task automatic chk_inc(input string nm, input bit upd, input int a);
      chk({nm, ".ek0"}, inc_ek0, upd ? x0[a] : 0);
      chk({nm, ".ek1"}, inc_ek1, upd ? x1[a] : 0);
      chk({nm, ".ek2"}, inc_ek2, upd ? x2[a] : 0);
      chk({nm, ".kp"},  inc_kp,  upd ? xkp[a] : 0);
      chk({nm, ".ki"},  inc_ki,  upd ? xki[a] : 0);
      chk({nm, ".kd"},  inc_kd,  upd ? xkd[a] : 0);
   endtask

   task automatic run_sample(input vec_t v, input string nm);
      bit upd;
      apply_cfg(v);
      while (ph != SD - 3) step();
      if (v.give && !v.coinc) begin
         drive_coord(v); step(); coord_valid = 1'b0;
      end
      while (ph != SD - 1) step();
      if (v.give && v.coinc) drive_coord(v);
      model_tick(v, upd);
      step();                                      // T+1
      coord_valid = 1'b0;
      chk({nm, ".uv1"}, u_valid, 0);
      chk({nm, ".busy1"}, busy, upd);
      chk({nm, ".load_ek0"}, inc_ek0, 0);
      step();                                      // T+2, X accumulates
      chk_inc({nm, ".accx"}, upd, 0);
      step();                                      // T+3
      chk({nm, ".pan3"}, pan_u, m_u[0]);
      step();                                      // T+4, Y accumulates
      chk_inc({nm, ".accy"}, upd, 1);
      step();                                      // T+5
      chk({nm, ".uv5"}, u_valid, upd);
      chk({nm, ".pan5"}, pan_u, m_u[0]);
      chk({nm, ".tilt5"}, tilt_u, m_u[1]);
      if (v.has_exp) begin
         chk({nm, ".pan_tbl"}, pan_u, v.exp_pan);
         chk({nm, ".tilt_tbl"}, tilt_u, v.exp_tilt);
      end
      step();                                      // T+6
      chk({nm, ".uv6"}, u_valid, 0);
      chk({nm, ".busy6"}, busy, 0);
      $display("sample %s upd=%0d pan=%0d tilt=%0d", nm, upd, pan_u, tilt_u);
   endtask

   task automatic reset_check(input int n, input string nm);
      rst_n = 1'b0; coord_valid = 1'b0;
      repeat (n) step();
      chk({nm, ".pan"}, pan_u, 0);
      chk({nm, ".tilt"}, tilt_u, 0);
      chk({nm, ".uv"}, u_valid, 0);
      chk({nm, ".busy"}, busy, 0);
      chk({nm, ".ovr"}, overrun, 0);
      chk({nm, ".ek0"}, inc_ek0, 0);
      chk({nm, ".kp"}, inc_kp, 0);
      rst_n = 1'b1;
      ph = 0;
      model_reset();
      $display("reset %s done", nm);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [9];
      vec_t v;
      bit upd;
      //          tx    x    ty    y  kpx kix kdx kpy kiy kdy give coinc frc fval  exp pan  tilt
      tbl[0] = '{   0, -100,   0,   0, 2, 0, 0, 2, 0, 0, 1, 0, 0,      0, 1,   200,     0};
      tbl[1] = '{   0,    0,   0,   0, 2, 0, 0, 2, 0, 0, 0, 0, 0,      0, 1,   200,     0};
      tbl[2] = '{   0,  -50,  10,   0, 2, 0, 0, 2, 0, 0, 1, 1, 0,      0, 1,   100,    20};
      tbl[3] = '{ 511, -512,-512, 511, 2, 0, 0, 2, 0, 0, 1, 0, 0,      0, 1,  1022, -1024};
      tbl[4] = '{   0,    0,   0,   0, 2, 0, 0, 2, 0, 0, 1, 0, 1,  16383, 1, 16383, 15359};
      tbl[5] = '{   0,    0,   0,   0, 2, 0, 0, 2, 0, 0, 1, 0, 1,  16383, 1, 16383, 16383};
      tbl[6] = '{   0,    0,   0,   0, 2, 0, 0, 2, 0, 0, 1, 0, 1, -16384, 1,    -1,    -1};
      tbl[7] = '{   0,    0,   0,   0, 2, 0, 0, 2, 0, 0, 1, 0, 1, -16384, 1,-16384,-16384};
      tbl[8] = '{   0,    0,   0,   0, 2, 0, 0, 2, 0, 0, 1, 0, 1, -16384, 1,-16384,-16384};

      model_reset();
      reset_check(3, "por");

      for (int i = 0; i < 9; i++) run_sample(tbl[i], $sformatf("tbl%0d", i));

      for (int i = 0; i < 150; i++) begin
         v.tx = int'($urandom_range(0, 1023)) - 512;
         v.x  = int'($urandom_range(0, 1023)) - 512;
         v.ty = int'($urandom_range(0, 1023)) - 512;
         v.y  = int'($urandom_range(0, 1023)) - 512;
         v.kp_x = int'($urandom_range(0, 15)); v.ki_x = int'($urandom_range(0, 15));
         v.kd_x = int'($urandom_range(0, 15)); v.kp_y = int'($urandom_range(0, 15));
         v.ki_y = int'($urandom_range(0, 15)); v.kd_y = int'($urandom_range(0, 15));
         v.give  = ($urandom_range(0, 3) != 0);
         v.coinc = ($urandom_range(0, 2) == 0);
         v.frc = 1'b0; v.fval = 0; v.has_exp = 1'b0; v.exp_pan = 0; v.exp_tilt = 0;
         run_sample(v, $sformatf("rnd%0d", i));
      end
      chk("ovr_after_rnd", overrun, 0);

      // Reset held for 3 cycles in the middle of the Y accumulate cycle.
      v = tbl[0];
      v.y = -30;
      apply_cfg(v);
      while (ph != SD - 3) step();
      drive_coord(v); step(); coord_valid = 1'b0;
      while (ph != SD - 1) step();
      repeat (4) step();
      chk("midrst.busy_pre", busy, 1);
      reset_check(3, "midrst");
      run_sample(tbl[0], "after_rst");

      // Extra tick injected while the X axis accumulates.
      v = tbl[2];
      v.coinc = 1'b0;
      apply_cfg(v);
      while (ph != SD - 3) step();
      drive_coord(v); step(); coord_valid = 1'b0;
      while (ph != SD - 1) step();
      model_tick(v, upd);
      step(); step();                              // T+2
      chk("ovr.pre", overrun, 0);
      force dut.tick = 1'b1;
      step();                                      // T+3
      release dut.tick;
      chk("ovr.set", overrun, 1);
      chk("ovr.pan3", pan_u, m_u[0]);
      step(); step();                              // T+5
      chk("ovr.uv5", u_valid, 1);
      chk("ovr.pan5", pan_u, m_u[0]);
      chk("ovr.tilt5", tilt_u, m_u[1]);
      step();
      chk("ovr.busy6", busy, 0);
      chk("ovr.sticky", overrun, 1);
      $display("overrun sample pan=%0d tilt=%0d overrun=%0d", pan_u, tilt_u, overrun);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pid_axis_sched.md
Name: pid_axis_sched

Overview:
Sequences one shared combinational incremental-PID increment unit between two axes: pan (X) and tilt (Y) of the ball-tracking gimbal.
- Generates the control sample rate and snapshots the latest ball centroid.
- Holds per-axis error history and accumulated output.
- Time-multiplexes the increment unit over X then Y.
- Saturates and publishes both servo commands with a valid strobe.
- Sits between the centroid/ball-finder stage and the servo PWM generators.

Parameters:
SAMPLE_DIV, 1_000_000, clk cycles per control sample (≥8).
U_MAX, 16383, upper saturation of accumulated output (signed 15-bit).
U_MIN, -16384, lower saturation of accumulated output.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
coord_valid  in  1  pulse: new centroid on x_pos/y_pos
x_pos  in  10 signed  ball centroid X
y_pos  in  10 signed  ball centroid Y
target_x  in  10 signed  X setpoint
target_y  in  10 signed  Y setpoint
kp_x, ki_x, kd_x  in  4 each  X gains
kp_y, ki_y, kd_y  in  4 each  Y gains
inc_ek0, inc_ek1, inc_ek2  out  10 signed each  errors to increment unit
inc_kp, inc_ki, inc_kd  out  4 each  gains to increment unit
inc_d_uk  in  15 signed  increment result (combinational, same cycle)
pan_u  out  15 signed  X command
tilt_u  out  15 signed  Y command
u_valid  out  1  one-cycle pulse: pan_u/tilt_u updated
busy  out  1  FSM not in IDLE
overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset (rst_n low at a clk edge): all registers 0 — pan_u, tilt_u, error histories, sample counter, fresh flag, overrun, u_valid. FSM goes to IDLE. Reset mid-sequence aborts with no partial update.
- Sample counter: counts 0..SAMPLE_DIV-1. tick is asserted for one cycle at SAMPLE_DIV-1, then the counter wraps to 0.
- Capture: coord_valid latches x_pos/y_pos into shadow regs and sets fresh.
  - coord_valid coincident with tick: the new coordinate is used for this sample.
- FSM states: IDLE → LOAD_X → ACC_X → LOAD_Y → ACC_Y → DONE → IDLE.
- IDLE:
  - On tick with fresh=1: snapshot shadow regs, clear fresh, go to LOAD_X.
  - On tick with fresh=0: stay in IDLE, no update, histories unchanged, no u_valid.
- LOAD_X: compute ex = target_x - x_snap in 11 bits, saturate to [-512, 511]. Register it as ek0_x.
- ACC_X:
  - Drive inc_* with ek0_x, ek1_x, ek2_x and kp_x/ki_x/kd_x.
  - pan_u <= sat(pan_u + inc_d_uk) in 16 bits, clamped to [U_MIN, U_MAX].
  - Shift history: ek2_x <= ek1_x, ek1_x <= ek0_x.
- LOAD_Y / ACC_Y: same as LOAD_X / ACC_X for the Y axis, updating tilt_u.
- DONE: u_valid = 1 for one cycle, then IDLE.
- Latency: tick at cycle T → u_valid at T+5. pan_u is stable from T+3 and tilt_u from T+5.
- Increment-unit outputs outside ACC_X/ACC_Y are driven to 0.
- Gains are sampled only in ACC states; changes between samples take effect at the next sample.
- Tick while busy: the tick is dropped and overrun is set. overrun clears only on reset. Unreachable while SAMPLE_DIV ≥ 8, but required for robustness.

Decomposition:
- Shared package pid_pkg holds:
  - width constants: E_W=10, G_W=4, U_W=15;
  - FSM state enum;
  - saturate-to-width functions (11→10 and 16→15).
- One natural sub-module: pid_sample_tick, the SAMPLE_DIV counter with tick output.

Test Plan:
- Reset: hold rst_n low 3 cycles mid-ACC_Y → all outputs 0, busy=0, histories 0; next sample behaves as the first.
- Single sample: target_x=0, x_pos=-100, target_y=0, y_pos=0, increment-unit model d_uk=kp*(ek0-ek1) with kp_x=kp_y=2 → u_valid at T+5, pan_u=200, tilt_u=0.
- Stale data: no coord_valid before the second tick → no u_valid, pan_u holds 200, ek1_x still 100.
- Error saturation: target_x=511, x_pos=-512 → inc_ek0=511.
- Output saturation: force d_uk=16383 for two samples → pan_u=16383; then d_uk=-16384 ×3 → pan_u=-16384.
- Coincidence/overrun: coord_valid on the tick cycle → that coordinate is used. With the bench forcing an internal tick while busy, overrun=1 and the sequence completes normally.
